arm_alu: RTL and testbench
==========================

Name: arm_alu

Overview:
- 32-bit combinational ARM-style ALU with an NZCV status-flag register.
- Computes the result and the flags from two operands, a 3-bit operation code and a carry input.
- Registered flags (flags_q) hold the processor's condition state and are updated on clk when flags_we is asserted.
- Sits in the execute stage of the single-cycle ARM datapath.

Parameters:
WIDTH, 32, operand/result width in bits (flag logic uses bit WIDTH-1 as sign).

Ports:
clk  input  1  clock; flags register updates on rising edge
reset  input  1  synchronous, active-low reset
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
alu_control  input  3  operation select
carry  input  1  carry-in for ADC/SBC (normally flags_q[1])
flags_we  input  1  write-enable for flags register
alu_result  output  WIDTH  combinational result
alu_flags  output  4  combinational {N,Z,C,V} of current operation
flags_q  output  4  registered {N,Z,C,V}

Behaviour:
- Reset: clk is clk; reset is synchronous, active-low. reset=0 at a rising edge sets flags_q=4'b0000. alu_result and alu_flags are combinational and unaffected by reset.
- alu_control encoding (all arithmetic modulo 2^WIDTH):
  - 000 ADD: A+B
  - 001 SUB: A+~B+1
  - 010 AND: A&B
  - 011 ORR: A|B
  - 100 EOR: A^B
  - 101 ADC: A+B+carry
  - 110 SBC: A+~B+carry
  - 111 RSB: B+~A+1
- Arithmetic core: one (WIDTH+1)-bit adder, sum = X + Y' + cin.
  - X is the first operand: A, or B for RSB.
  - Y' is the conditionally inverted second operand (condinvb).
  - cin is carryin: 0 for ADD; 1 for SUB and RSB; the carry input for ADC and SBC.
- Flags (alu_flags, bit3..0 = N,Z,C,V):
  - N = result[WIDTH-1].
  - Z = (result==0).
  - C = adder carry-out for arithmetic ops, 0 for logic ops. For SUB, C=1 means no borrow (A>=B unsigned).
  - V = ~(X[msb]^Y'[msb]) & (sum[msb]^X[msb]) for arithmetic ops, 0 for logic ops.
- Latency: alu_result and alu_flags settle within the same cycle (zero latency).
- flags_q: on a rising edge with reset=1 and flags_we=1, flags_q <= alu_flags. With flags_we=0, flags_q holds.
- Reset has priority over flags_we.
- No X propagation from unused paths. Every alu_control value is defined; there is no illegal code.

Decomposition:
- Shared package arm_alu_pkg holds:
  - enum alu_op_e with ADD, SUB, AND, ORR, EOR, ADC, SBC, RSB.
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module is natural: arm_alu_adder, a parameterized WIDTH+1 adder returning sum, carry-out and overflow.
- Result mux and flag register stay in arm_alu.

Test Plan:
- Reset: reset=0 for one rising edge -> flags_q=0000. Then reset=1, flags_we=0, any op -> flags_q stays 0000.
- ADD: A=0x00000001, B=0xFFFFFFFF, ctl=000 -> result=0x00000000, flags=0110. ADD A=0x7FFFFFFF, B=0x00000001 -> 0x80000000, flags=1001.
- SUB: A=5, B=3, ctl=001 -> 0x00000002, flags=0010. A=3, B=5 -> 0xFFFFFFFE, flags=1000. A=0x80000000, B=1 -> 0x7FFFFFFF, flags=0011.
- Logic ops: A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND -> 0x00F000F0, flags=0000.
  - ORR -> 0xFFF0FFF0, flags=1000.
  - EOR -> 0xFF00FF00, flags=1000.
  - Logic ops ignore carry=1 (C stays 0).
- Carry ops:
  - ADC A=1, B=2, carry=1 -> 0x00000004.
  - SBC A=5, B=3, carry=0 -> 0x00000001, C=1.
  - RSB A=3, B=10 -> 0x00000007, flags=0010.
- Flag register: SUB A=3, B=3 with flags_we=1 -> after the rising edge flags_q=0110. Next cycle ADD 1+1 with flags_we=0 -> flags_q remains 0110. Asserting reset=0 together with flags_we=1 -> flags_q=0000.

Source files
------------

// File: rtl/arm_alu_pkg.sv
// Shared types and constants for the ARM-style ALU.
package arm_alu_pkg;

  // Operation select, matching the datapath's alu_control encoding.
  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    ORR = 3'b011,
    EOR = 3'b100,
    ADC = 3'b101,
    SBC = 3'b110,
    RSB = 3'b111
  } alu_op_e;

  // Bit positions inside the {N,Z,C,V} flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu_if.sv
// Operand/result bundle between the execute-stage control and the ALU.
interface arm_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [2:0]       alu_control;
  logic             carry;
  logic             flags_we;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       flags_q;

  modport master (
    output src_a, src_b, alu_control, carry, flags_we,
    input  alu_result, alu_flags, flags_q
  );

  modport slave (
    input  src_a, src_b, alu_control, carry, flags_we,
    output alu_result, alu_flags, flags_q
  );
endinterface

// File: rtl/arm_alu_adder.sv
// Single WIDTH+1 bit adder shared by every arithmetic operation.
// The caller supplies the already-selected/inverted operands.
module arm_alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf  = ~(x[WIDTH-1] ^ y[WIDTH-1]) & (sum[WIDTH-1] ^ x[WIDTH-1]);
endmodule

// File: rtl/arm_alu.sv
// ARM-style 32-bit ALU: combinational result/NZCV plus a registered flag copy.
module arm_alu
  import arm_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  arm_alu_if.slave  bus
);
  alu_op_e          op;
  logic [WIDTH-1:0] x, y;
  logic             cin;
  logic             arith;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [3:0]       flags_r;

  assign op = alu_op_e'(bus.alu_control);

  // Steer operands and carry-in into the shared adder; logic ops bypass it.
  always_comb begin
    x     = bus.src_a;
    y     = ~bus.src_b;
    cin   = 1'b1;
    arith = 1'b1;
    case (op)
      ADD: begin y = bus.src_b; cin = 1'b0; end
      SUB: ;
      ADC: begin y = bus.src_b; cin = bus.carry; end
      SBC: cin = bus.carry;
      RSB: begin x = bus.src_b; y = ~bus.src_a; end
      AND, ORR, EOR: arith = 1'b0;
      default: ;
    endcase
  end

  arm_alu_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (x),
    .y    (y),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Result select: adder output for arithmetic, bitwise ops otherwise.
  always_comb begin
    result = sum;
    case (op)
      AND:     result = bus.src_a & bus.src_b;
      ORR:     result = bus.src_a | bus.src_b;
      EOR:     result = bus.src_a ^ bus.src_b;
      default: result = sum;
    endcase
  end

  // NZCV; C and V are forced low for logic ops so carry-in never leaks through.
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = arith & cout;
    flags[FLAG_V] = arith & ovf;
  end

  // Condition-state register; reset wins over the write enable.
  always_ff @(posedge clk) begin
    if (!reset)            flags_r <= 4'b0000;
    else if (bus.flags_we) flags_r <= flags;
  end

  assign bus.alu_result = result;
  assign bus.alu_flags  = flags;
  assign bus.flags_q    = flags_r;
endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed vectors plus randomized ops
// against an integer-arithmetic reference model.
module tb_arm_alu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [3:0] exp_q = 4'b0000;

  arm_alu_if #(.WIDTH(32)) bus ();

  arm_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {result, N, Z, C, V} from signed/unsigned integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic c);
    longint     sa, sb, s;
    longint     ua, ub, u;
    logic [31:0] r;
    logic       cf, vf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    s  = 0;
    cf = 1'b0;
    vf = 1'b0;
    case (op)
      3'd0: begin s = sa + sb;              u = ua + ub;                   cf = u > 64'hFFFF_FFFF; end
      3'd1: begin s = sa - sb;              cf = (ua >= ub); end
      3'd5: begin s = sa + sb + longint'(c); u = ua + ub + longint'(c);    cf = u > 64'hFFFF_FFFF; end
      3'd6: begin s = sa - sb - 1 + longint'(c); cf = (ua + longint'(c) > ub); end
      3'd7: begin s = sb - sa;              cf = (ub >= ua); end
      default: ;
    endcase
    case (op)
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: begin
        r  = s[31:0];
        vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    return {r, r[31], (r == 32'h0), cf, vf};
  endfunction

  // One cycle: drive after negedge, check combinational, clock, check flags_q.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic c, input logic we, input logic rst,
                      input logic use_k, input logic [31:0] kr, input logic [3:0] kf);
    logic [35:0] m;
    bus.src_a = a; bus.src_b = b; bus.alu_control = op;
    bus.carry = c; bus.flags_we = we; reset = rst;
    m = model(a, b, op, c);
    #1;
    chk({tag, ".res"}, bus.alu_result, m[35:4]);
    chk({tag, ".flg"}, {28'b0, bus.alu_flags}, {28'b0, m[3:0]});
    if (use_k) begin
      chk({tag, ".kres"}, bus.alu_result, kr);
      chk({tag, ".kflg"}, {28'b0, bus.alu_flags}, {28'b0, kf});
    end
    @(posedge clk);
    if (!rst) exp_q = 4'b0000;
    else if (we) exp_q = m[3:0];
    @(negedge clk);
    chk({tag, ".fq"}, {28'b0, bus.flags_q}, {28'b0, exp_q});
  endtask

  initial begin
    bus.src_a = '0; bus.src_b = '0; bus.alu_control = '0;
    bus.carry = 1'b0; bus.flags_we = 1'b0;
    @(negedge clk);
    // reset, then hold with flags_we low
    step("rst",   32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    step("hold",  32'h7FFFFFFF, 32'h1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("rst.zero", {28'b0, bus.flags_q}, 32'h0);
    // directed vectors with hand-derived expectations
    step("add0",  32'h00000001, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000000, 4'b0110);
    step("addv",  32'h7FFFFFFF, 32'h00000001, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 4'b1001);
    step("sub1",  32'd5, 32'd3, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000002, 4'b0010);
    step("sub2",  32'd3, 32'd5, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFE, 4'b1000);
    step("subv",  32'h80000000, 32'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 4'b0011);
    step("and",   32'hF0F0F0F0, 32'h0FF00FF0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00F000F0, 4'b0000);
    step("orr",   32'hF0F0F0F0, 32'h0FF00FF0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFF0FFF0, 4'b1000);
    step("eor",   32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFF00FF00, 4'b1000);
    step("adc",   32'd1, 32'd2, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000004, 4'b0000);
    step("sbc",   32'd5, 32'd3, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000001, 4'b0010);
    step("rsb",   32'd3, 32'd10, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000007, 4'b0010);
    // flag register write / hold / reset priority
    step("fwr",   32'd3, 32'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000, 4'b0110);
    chk("fwr.k",  {28'b0, bus.flags_q}, 32'h6);
    step("fhold", 32'd1, 32'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000002, 4'b0000);
    chk("fhold.k", {28'b0, bus.flags_q}, 32'h6);
    step("frst",  32'h7FFFFFFF, 32'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("frst.k", {28'b0, bus.flags_q}, 32'h0);
    // randomized ops, biased toward corner operands
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = a;
        3: a = 32'h7FFFFFFF;
        default: ;
      endcase
      step("rnd", a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0), 1'b0, 32'h0, 4'h0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
